// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind game datapath and sequencer.
// Holds the game state encoding, default game geometry and the score/colour widths.
package mastermind_pkg;

    typedef enum logic [2:0] {
        ST_NEW   = 3'd0,
        ST_ENTRY = 3'd1,
        ST_SCORE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } game_state_t;

    localparam int CODE_LEN_DEF  = 4;
    localparam int MAX_TURNS_DEF = 8;
    localparam int COLOUR_W      = 3;
    localparam int SCORE_W       = COLOUR_W;
    localparam int LAT_W         = 3;

    // True when every peg of the guess sits in its exact position.
    function automatic logic score_is_win(input logic [SCORE_W-1:0] exact,
                                          input int                 code_len);
        return (exact == SCORE_W'(code_len));
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge strobe for an already-debounced button level.
// The level is registered once; the strobe is high for the single cycle after a 0->1 change.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_r;
    logic btn_prev_r;

    // Sample the button level and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_r      <= 1'b0;
            btn_prev_r <= 1'b0;
        end else begin
            btn_r      <= btn;
            btn_prev_r <= btn_r;
        end
    end

    assign rise = btn_r & ~btn_prev_r;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: secret-code capture, guess commit/scoring handshake,
// turn counting and sticky win/lose. All outputs come straight from registers.
module mastermind_game_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_TURNS = MAX_TURNS_DEF,
    parameter int CODE_LEN  = CODE_LEN_DEF,
    parameter int SCORE_LAT = 2,
    parameter int TURN_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               btn_select,
    input  logic               btn_new,
    input  logic [SCORE_W-1:0] score_exact,
    input  logic [SCORE_W-1:0] score_partial,
    output logic               code_load,
    output logic               guess_enable,
    output logic               hist_we,
    output logic [TURN_W-1:0]  hist_waddr,
    output logic               score_start,
    output logic [TURN_W-1:0]  turns_used,
    output logic               last_turn,
    output logic               win,
    output logic               lose,
    output logic               game_over
);

    localparam logic [TURN_W-1:0] MAX_C       = TURN_W'(MAX_TURNS);
    localparam logic [TURN_W-1:0] LAST_C      = TURN_W'(MAX_TURNS - 1);
    localparam logic [LAT_W-1:0]  SCORE_LAT_C = LAT_W'(SCORE_LAT);

    game_state_t       state_r, state_next_s;
    logic [LAT_W-1:0]  wait_r, wait_next_s;
    logic [TURN_W-1:0] turns_used_r, turns_next_s;
    logic [TURN_W-1:0] hist_waddr_r, hist_waddr_next_s;
    logic              win_r, win_next_s;
    logic              lose_r, lose_next_s;
    logic              code_load_r, code_load_next_s;
    logic              hist_we_r, hist_we_next_s;
    logic              score_start_r, score_start_next_s;
    logic              guess_enable_r, guess_enable_next_s;
    logic              last_turn_r, last_turn_next_s;
    logic              game_over_r, game_over_next_s;
    logic              sel_rise_s;
    logic              new_rise_s;
    logic              unused_partial_s;

    // Partial matches only feed the display path.
    assign unused_partial_s = ^score_partial;

    btn_edge u_sel_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_select),
        .rise (sel_rise_s)
    );

    btn_edge u_new_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_new),
        .rise (new_rise_s)
    );

    function automatic logic [TURN_W-1:0] sat_inc(input logic [TURN_W-1:0] v);
        if (v < MAX_C) begin
            return v + TURN_W'(1);
        end else begin
            return v;
        end
    endfunction

    // Next-state and next-output decode; outputs are derived from the next state so they line up with it.
    always_comb begin
        state_next_s        = state_r;
        wait_next_s         = wait_r;
        turns_next_s        = turns_used_r;
        hist_waddr_next_s   = hist_waddr_r;
        win_next_s          = win_r;
        lose_next_s         = lose_r;
        hist_we_next_s      = 1'b0;
        score_start_next_s  = 1'b0;
        code_load_next_s    = 1'b0;
        guess_enable_next_s = 1'b0;
        last_turn_next_s    = 1'b0;
        game_over_next_s    = 1'b0;

        case (state_r)
            // After reset code_load_r is 0, so NEW lingers one cycle to emit its pulse.
            ST_NEW: begin
                if (code_load_r) begin
                    state_next_s = ST_ENTRY;
                end else begin
                    state_next_s = ST_NEW;
                end
            end
            ST_ENTRY: begin
                if (new_rise_s) begin
                    state_next_s = ST_NEW;
                end else if (sel_rise_s && !mode) begin
                    state_next_s       = ST_SCORE;
                    wait_next_s        = {LAT_W{1'b0}};
                    hist_we_next_s     = 1'b1;
                    score_start_next_s = 1'b1;
                    hist_waddr_next_s  = turns_used_r;
                end else begin
                    state_next_s = ST_ENTRY;
                end
            end
            ST_SCORE: begin
                if (new_rise_s) begin
                    state_next_s = ST_NEW;
                end else if (wait_r == SCORE_LAT_C) begin
                    state_next_s = ST_CHECK;
                end else begin
                    wait_next_s = wait_r + LAT_W'(1);
                end
            end
            ST_CHECK: begin
                if (new_rise_s) begin
                    state_next_s = ST_NEW;
                end else begin
                    turns_next_s = sat_inc(turns_used_r);
                    if (score_is_win(score_exact, CODE_LEN)) begin
                        win_next_s   = 1'b1;
                        state_next_s = ST_DONE;
                    end else if (turns_next_s == MAX_C) begin
                        lose_next_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ENTRY;
                    end
                end
            end
            ST_DONE: begin
                if (new_rise_s) begin
                    state_next_s = ST_NEW;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_NEW;
            end
        endcase

        if (state_next_s == ST_NEW) begin
            code_load_next_s  = 1'b1;
            turns_next_s      = {TURN_W{1'b0}};
            hist_waddr_next_s = {TURN_W{1'b0}};
            win_next_s        = 1'b0;
            lose_next_s       = 1'b0;
        end else begin
            code_load_next_s = 1'b0;
        end

        guess_enable_next_s = (state_next_s == ST_ENTRY) && !mode;
        last_turn_next_s    = (state_next_s == ST_ENTRY) && (turns_next_s == LAST_C);
        game_over_next_s    = win_next_s | lose_next_s;
    end

    // State, counters and registered outputs; reset aborts any scoring in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_NEW;
            wait_r         <= {LAT_W{1'b0}};
            turns_used_r   <= {TURN_W{1'b0}};
            hist_waddr_r   <= {TURN_W{1'b0}};
            win_r          <= 1'b0;
            lose_r         <= 1'b0;
            code_load_r    <= 1'b0;
            hist_we_r      <= 1'b0;
            score_start_r  <= 1'b0;
            guess_enable_r <= 1'b0;
            last_turn_r    <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            wait_r         <= wait_next_s;
            turns_used_r   <= turns_next_s;
            hist_waddr_r   <= hist_waddr_next_s;
            win_r          <= win_next_s;
            lose_r         <= lose_next_s;
            code_load_r    <= code_load_next_s;
            hist_we_r      <= hist_we_next_s;
            score_start_r  <= score_start_next_s;
            guess_enable_r <= guess_enable_next_s;
            last_turn_r    <= last_turn_next_s;
            game_over_r    <= game_over_next_s;
        end
    end

    assign code_load    = code_load_r;
    assign guess_enable = guess_enable_r;
    assign hist_we      = hist_we_r;
    assign hist_waddr   = hist_waddr_r;
    assign score_start  = score_start_r;
    assign turns_used   = turns_used_r;
    assign last_turn    = last_turn_r;
    assign win          = win_r;
    assign lose         = lose_r;
    assign game_over    = game_over_r;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl: reset, guess commit timing, browse mode,
// win/lose detection, new-game abort and asynchronous reset mid-scoring.
module tb_mastermind_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       btn_select;
    logic       btn_new;
    logic [2:0] score_exact;
    logic [2:0] score_partial;
    logic       code_load;
    logic       guess_enable;
    logic       hist_we;
    logic [3:0] hist_waddr;
    logic       score_start;
    logic [3:0] turns_used;
    logic       last_turn;
    logic       win;
    logic       lose;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int ss_cnt = 0;
    int cl_cnt = 0;
    int last_waddr = 0;
    int we_snap;
    int cl_snap;
    int ss_snap;

    mastermind_game_ctrl #(
        .MAX_TURNS (8),
        .CODE_LEN  (4),
        .SCORE_LAT (2),
        .TURN_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .btn_select    (btn_select),
        .btn_new       (btn_new),
        .score_exact   (score_exact),
        .score_partial (score_partial),
        .code_load     (code_load),
        .guess_enable  (guess_enable),
        .hist_we       (hist_we),
        .hist_waddr    (hist_waddr),
        .score_start   (score_start),
        .turns_used    (turns_used),
        .last_turn     (last_turn),
        .win           (win),
        .lose          (lose),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (hist_we === 1'b1) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= int'(hist_waddr);
        end
        if (score_start === 1'b1) ss_cnt <= ss_cnt + 1;
        if (code_load === 1'b1) cl_cnt <= cl_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic guess(input logic [2:0] ex);
        score_exact = ex;
        btn_select  = 1'b1;
        tick(1);
        btn_select  = 1'b0;
        tick(8);
    endtask

    task automatic new_game();
        btn_new = 1'b1;
        tick(2);
        btn_new = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; btn_select = 1'b0; btn_new = 1'b0;
        score_exact = 3'd0; score_partial = 3'd0;
        #1 rst = 1'b1;
        tick(2);
        chk("rst_code_load", 32'(code_load), 32'd0);
        chk("rst_guess_enable", 32'(guess_enable), 32'd0);
        chk("rst_hist_we", 32'(hist_we), 32'd0);
        chk("rst_score_start", 32'(score_start), 32'd0);
        chk("rst_turns", 32'(turns_used), 32'd0);
        chk("rst_win_lose_over", 32'({win, lose, game_over, last_turn}), 32'd0);

        rst = 1'b0;
        tick(1);
        chk("new_code_load", 32'(code_load), 32'd1);
        chk("new_guess_enable", 32'(guess_enable), 32'd0);
        tick(1);
        chk("entry_code_load", 32'(code_load), 32'd0);
        chk("entry_guess_enable", 32'(guess_enable), 32'd1);
        chk("entry_turns", 32'(turns_used), 32'd0);

        // Held Select: exactly one commit, two cycles after the press.
        score_exact = 3'd1; score_partial = 3'd2; btn_select = 1'b1;
        tick(1);
        chk("sel_lat1_hist_we", 32'(hist_we), 32'd0);
        tick(1);
        chk("sel_lat2_hist_we", 32'(hist_we), 32'd1);
        chk("sel_score_start", 32'(score_start), 32'd1);
        chk("sel_waddr", 32'(hist_waddr), 32'd0);
        chk("score_guess_enable", 32'(guess_enable), 32'd0);
        tick(1);
        chk("hist_we_pulse", 32'(hist_we), 32'd0);
        tick(2);
        chk("check_turns_before", 32'(turns_used), 32'd0);
        tick(1);
        chk("check_turns_after", 32'(turns_used), 32'd1);
        chk("back_entry_enable", 32'(guess_enable), 32'd1);
        tick(14);
        btn_select = 1'b0;
        tick(2);
        chk("held_we_count", 32'(we_cnt), 32'd1);
        chk("held_ss_count", 32'(ss_cnt), 32'd1);

        // Browse mode owns Select.
        mode = 1'b1;
        tick(1);
        chk("browse_guess_enable", 32'(guess_enable), 32'd0);
        btn_select = 1'b1;
        tick(3);
        btn_select = 1'b0;
        tick(6);
        chk("browse_we_count", 32'(we_cnt), 32'd1);
        chk("browse_ss_count", 32'(ss_cnt), 32'd1);
        chk("browse_turns", 32'(turns_used), 32'd1);
        mode = 1'b0;
        tick(1);
        chk("entry_again_enable", 32'(guess_enable), 32'd1);

        guess(3'd2);
        chk("g2_turns", 32'(turns_used), 32'd2);
        chk("g2_waddr", 32'(last_waddr), 32'd1);
        guess(3'd4);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_game_over", 32'(game_over), 32'd1);
        chk("win_lose", 32'(lose), 32'd0);
        chk("win_turns", 32'(turns_used), 32'd3);
        chk("done_guess_enable", 32'(guess_enable), 32'd0);
        guess(3'd0);
        chk("done_sel_ignored_we", 32'(we_cnt), 32'd3);
        chk("done_sel_ignored_turns", 32'(turns_used), 32'd3);
        chk("done_win_held", 32'(win), 32'd1);

        // New game from DONE.
        btn_new = 1'b1;
        tick(1);
        chk("ng_lat1_code_load", 32'(code_load), 32'd0);
        tick(1);
        chk("ng_code_load", 32'(code_load), 32'd1);
        chk("ng_turns", 32'(turns_used), 32'd0);
        chk("ng_win_cleared", 32'({win, game_over}), 32'd0);
        btn_new = 1'b0;
        tick(1);
        chk("ng_entry_enable", 32'(guess_enable), 32'd1);

        // Eight misses lose the game.
        for (int i = 0; i < 6; i++) guess(3'd0);
        chk("lose_t6_turns", 32'(turns_used), 32'd6);
        chk("lose_t6_last", 32'(last_turn), 32'd0);
        guess(3'd0);
        chk("lose_t7_turns", 32'(turns_used), 32'd7);
        chk("lose_t7_last", 32'(last_turn), 32'd1);
        guess(3'd1);
        chk("lose_flag", 32'(lose), 32'd1);
        chk("lose_win", 32'(win), 32'd0);
        chk("lose_turns", 32'(turns_used), 32'd8);
        chk("lose_over_last", 32'({game_over, last_turn}), 32'd2);
        chk("lose_last_waddr", 32'(last_waddr), 32'd7);

        // Win on the final turn beats lose.
        new_game();
        for (int i = 0; i < 7; i++) guess(3'd3);
        chk("final_last_turn", 32'(last_turn), 32'd1);
        guess(3'd4);
        chk("final_win", 32'(win), 32'd1);
        chk("final_lose", 32'(lose), 32'd0);
        chk("final_turns", 32'(turns_used), 32'd8);

        // Select and New on the same cycle: New wins, no write.
        new_game();
        we_snap = we_cnt;
        cl_snap = cl_cnt;
        btn_select = 1'b1; btn_new = 1'b1;
        tick(2);
        chk("both_code_load", 32'(code_load), 32'd1);
        chk("both_hist_we", 32'(hist_we), 32'd0);
        btn_select = 1'b0; btn_new = 1'b0;
        tick(2);
        chk("both_we_count", 32'(we_cnt), 32'(we_snap));
        chk("both_cl_count", 32'(cl_cnt), 32'(cl_snap + 1));
        chk("both_entry_enable", 32'(guess_enable), 32'd1);

        // New game during SCORE abandons the guess without a turn increment.
        guess(3'd1);
        chk("abort_pre_turns", 32'(turns_used), 32'd1);
        ss_snap = ss_cnt;
        btn_select = 1'b1;
        tick(1);
        btn_select = 1'b0;
        tick(1);
        chk("abort_hist_we", 32'(hist_we), 32'd1);
        btn_new = 1'b1;
        tick(1);
        chk("abort_lat1_code_load", 32'(code_load), 32'd0);
        tick(1);
        chk("abort_code_load", 32'(code_load), 32'd1);
        chk("abort_turns", 32'(turns_used), 32'd0);
        btn_new = 1'b0;
        tick(6);
        chk("abort_turns_stay", 32'(turns_used), 32'd0);
        chk("abort_entry_enable", 32'(guess_enable), 32'd1);
        chk("abort_ss_count", 32'(ss_cnt), 32'(ss_snap + 1));

        // Asynchronous reset mid-SCORE clears outputs without a clock edge.
        guess(3'd2);
        btn_select = 1'b1;
        tick(1);
        btn_select = 1'b0;
        tick(1);
        chk("arst_pre_hist_we", 32'(hist_we), 32'd1);
        chk("arst_pre_waddr", 32'(hist_waddr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_hist_we", 32'(hist_we), 32'd0);
        chk("arst_score_start", 32'(score_start), 32'd0);
        chk("arst_turns", 32'(turns_used), 32'd0);
        chk("arst_waddr", 32'(hist_waddr), 32'd0);
        chk("arst_flags", 32'({code_load, guess_enable, win, lose, game_over, last_turn}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("arst_new_code_load", 32'(code_load), 32'd1);
        tick(1);
        chk("arst_entry_enable", 32'(guess_enable), 32'd1);
        chk("arst_entry_turns", 32'(turns_used), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mastermind_game_ctrl.md
Name: mastermind_game_ctrl

Overview:
Top-level game sequencer for the Mastermind design; it sits between the debounced buttons/mode switch and the guess, history, PRNG and feedback blocks.
- Captures a secret code from the PRNG at game start.
- Gates guess editing, commits each guess into history on Select, and triggers scoring.
- Counts turns, detects win/lose, and holds the game-over state until a new game is requested.

Parameters:
MAX_TURNS, 8, guesses allowed per game (2..15)
CODE_LEN, 4, pegs per code; a win is score_exact == CODE_LEN
SCORE_LAT, 2, cycles from score_start to valid score_exact/score_partial (1..7)
TURN_W, 4, width of turn counters; must hold MAX_TURNS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mode  in  1  0 = guess entry, 1 = history browse (the board switch)
btn_select  in  1  debounced Select level
btn_new  in  1  debounced new-game request level
score_exact  in  3  exact-position matches from the feedback block
score_partial  in  3  colour-only matches from the feedback block
code_load  out  1  one-cycle pulse: PRNG value is latched as the secret code
guess_enable  out  1  guess editing allowed
hist_we  out  1  one-cycle pulse: write the current guess to history
hist_waddr  out  TURN_W  history slot for hist_we
score_start  out  1  one-cycle pulse: start comparing the committed guess
turns_used  out  TURN_W  guesses committed this game
last_turn  out  1  turns_used == MAX_TURNS-1 and state == ENTRY
win  out  1  sticky until a new game starts
lose  out  1  sticky until a new game starts
game_over  out  1  win | lose

Behaviour:
Reset values
- All outputs are 0 and the state is NEW on reset.
- Reset asserted in any state, including SCORE, aborts immediately. No partial history write completes after reset is deasserted.

Edge detection
- btn_select and btn_new each pass through a register. sel_rise and new_rise are single-cycle rising-edge strobes.
- A held button produces exactly one event.
- Edges that are ignored are dropped, not queued.

States
- NEW (1 cycle): code_load = 1 for this cycle. Clear turns_used, win and lose. Go to ENTRY.
- ENTRY: guess_enable = !mode.
  - If sel_rise && !mode: go to SCORE next cycle.
  - In that first SCORE cycle, hist_we = 1, score_start = 1 and hist_waddr = turns_used.
  - If sel_rise && mode: ignored; history browsing owns Select.
- SCORE: guess_enable = 0. A wait counter runs SCORE_LAT cycles after the score_start cycle, then the block goes to CHECK.
- CHECK (1 cycle): score_exact and score_partial are sampled here. turns_used increments by 1.
  - If score_exact == CODE_LEN: set win, go to DONE.
  - Else if the incremented turns_used == MAX_TURNS: set lose, go to DONE.
  - Else go to ENTRY.
  - Win takes precedence on the final turn.
- DONE: guess_enable = 0. sel_rise is ignored. win/lose are held.

New game
- new_rise in any state except NEW goes to NEW next cycle, with turns_used cleared there.
- If new_rise and sel_rise occur in the same cycle, new_rise wins and there is no hist_we.

Latency and widths
- Select edge to hist_we is 2 cycles: 1 cycle register plus 1 cycle state transition.
- hist_we to CHECK is SCORE_LAT + 1 cycles.
- turns_used saturates at MAX_TURNS and never wraps.
- score_partial is not used for decisions. It is consumed only by the display path and is listed here for port symmetry.

Decomposition:
- Shared package mastermind_pkg holds:
  - the state enum NEW/ENTRY/SCORE/CHECK/DONE;
  - the CODE_LEN and MAX_TURNS defaults;
  - the colour width constant (3).
- One natural sub-module, btn_edge, handles edge detection. It is instantiated twice, for select and new.
- The wait counter and turn counter stay inline.

Test Plan:
- Reset release -> NEW for 1 cycle with code_load = 1, then ENTRY. guess_enable = 1 with mode = 0; turns_used = 0, win = lose = 0.
- mode = 0, btn_select held 20 cycles; scores exact = 1, partial = 2 -> one hist_we with hist_waddr = 0. Check returns to ENTRY with turns_used = 1 and no second write.
- mode = 1, Select pressed -> no hist_we, no score_start, turns_used unchanged. guess_enable = 0 while mode = 1.
- Third guess scored with score_exact = 4 -> win = 1, game_over = 1, turns_used = 3. A further Select is ignored.
- Eight guesses, all with exact < 4 -> last_turn = 1 when turns_used = 7. After CHECK, lose = 1 and turns_used = 8.
- Eighth guess with exact = 4 -> win = 1, lose = 0.
- btn_new rises during SCORE -> NEW next cycle with code_load pulse, turns_used = 0 and no CHECK increment.
- Async rst asserted mid-SCORE -> all outputs go to 0 immediately, without waiting for a clock edge.
